// File: rtl/jts16b_mapper_pkg.sv
// Shared register map, command codes and access-sequence helpers for the
// System 16B mapper and its host-side sequencer.
package jts16b_mapper_pkg;

  localparam logic [4:0] REG_XFER0    = 5'd0;  // write-data high / read-data low
  localparam logic [4:0] REG_XFER1    = 5'd1;  // write-data low  / read-data high
  localparam logic [4:0] REG_STATUS   = 5'd2;
  localparam logic [4:0] REG_CMD      = 5'd5;
  localparam logic [4:0] REG_WADDR_HI = 5'd7;
  localparam logic [4:0] REG_WADDR_MD = 5'd8;
  localparam logic [4:0] REG_WADDR_LO = 5'd9;
  localparam logic [4:0] REG_RADDR_HI = 5'd10;
  localparam logic [4:0] REG_RADDR_MD = 5'd11;
  localparam logic [4:0] REG_RADDR_LO = 5'd12;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_READ      = 8'h02;
  localparam int         STATUS_BUSREQ = 6;

  localparam logic [2:0] WR_LAST_STEP = 3'd5;
  localparam logic [2:0] RD_LAST_STEP = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_SAMPLE, ST_POLL, ST_FETCH, ST_DONE
  } host_state_e;

  typedef struct packed {
    logic       we;
    logic [4:0] idx;
    logic [7:0] data;
  } reg_op_t;

  // Register operation for a given step of the address/command phase.
  // addr is the 68000 word address [23:1]; the command write is always last.
  function automatic reg_op_t seq_op(input logic we, input logic [2:0] step,
                                     input logic [22:0] addr, input logic [15:0] din);
    reg_op_t op;
    op = '{we: 1'b1, idx: REG_CMD, data: (we ? CMD_WRITE : CMD_READ)};
    if (we) begin
      case (step)
        3'd0: begin op.idx = REG_XFER0;    op.data = din[15:8];           end
        3'd1: begin op.idx = REG_XFER1;    op.data = din[7:0];            end
        3'd2: begin op.idx = REG_WADDR_HI; op.data = {1'b0, addr[22:16]}; end
        3'd3: begin op.idx = REG_WADDR_MD; op.data = addr[15:8];          end
        3'd4: begin op.idx = REG_WADDR_LO; op.data = addr[7:0];           end
        default: ;
      endcase
    end else begin
      case (step)
        3'd0: begin op.idx = REG_RADDR_HI; op.data = {1'b0, addr[22:16]}; end
        3'd1: begin op.idx = REG_RADDR_MD; op.data = addr[15:8];          end
        3'd2: begin op.idx = REG_RADDR_LO; op.data = addr[7:0];           end
        default: ;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/jts16b_mapper_regacc.sv
// One mapper register access: hold the address for ADDR_SETUP cycles, then
// either strobe a write for one cycle or sample the readback one cycle later.
module jts16b_mapper_regacc
  import jts16b_mapper_pkg::*;
#(
  parameter int ADDR_SETUP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  reg_op_t     op,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [15:0] mcu_addr,
  output logic [7:0]  mcu_dout,
  output logic        mcu_wr,
  output logic        mcu_acc,
  input  logic [7:0]  mcu_din
);

  localparam logic [7:0] WR_LAST = 8'(ADDR_SETUP - 1);
  localparam logic [7:0] RD_LAST = 8'(ADDR_SETUP);

  host_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  dout_q, dout_d;
  logic        we_q, we_d;
  logic        wr_q, wr_d;
  logic        acc_q, acc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    we_d    = we_q;
    wr_d    = 1'b0;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SETUP;
        cnt_d   = 8'd0;
        idx_d   = op.idx;
        dout_d  = op.we ? op.data : dout_q;
        we_d    = op.we;
        acc_d   = 1'b1;
      end
      ST_SETUP: begin
        cnt_d = cnt_q + 8'd1;
        if (we_q && cnt_q == WR_LAST) begin
          state_d = ST_STROBE;
          wr_d    = 1'b1;
        end else if (!we_q && cnt_q == RD_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_STROBE, ST_SAMPLE: begin
        state_d = ST_IDLE;
        acc_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 5'd0;
      dout_q  <= 8'd0;
      we_q    <= 1'b0;
      wr_q    <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      acc_q   <= acc_d;
    end
  end

  // Last cycle of the access; the sequencer latches mcu_din on this edge.
  assign done     = (state_q == ST_STROBE) || (state_q == ST_SAMPLE);
  assign rdata    = mcu_din;
  assign mcu_addr = {11'd0, idx_q};
  assign mcu_dout = dout_q;
  assign mcu_wr   = wr_q;
  assign mcu_acc  = acc_q;

endmodule

// File: rtl/jts16b_mapper_host.sv
// Host-side sequencer that performs a 68000 bus read or write through the
// mapper's MCU register window: address/command writes, status poll, data fetch.
module jts16b_mapper_host
  import jts16b_mapper_pkg::*;
#(
  parameter int ADDR_SETUP = 3,
  parameter int POLL_MAX   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_din,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] req_dout,
  output logic [15:0] mcu_addr,
  output logic [7:0]  mcu_dout,
  output logic        mcu_wr,
  output logic        mcu_acc,
  input  logic [7:0]  mcu_din
);

  localparam logic [7:0] POLL_LIM = 8'(POLL_MAX);

  host_state_e state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  poll_q, poll_d, poll_nxt;
  logic        we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  logic [15:0] dout_q, dout_d;
  logic [7:0]  hi_q, hi_d;

  reg_op_t     op;
  logic        acc_done;
  logic [7:0]  acc_rdata;

  always_comb begin
    op = seq_op(we_q, step_q, addr_q, din_q);
    if (state_q == ST_POLL)
      op = '{we: 1'b0, idx: REG_STATUS, data: 8'h00};
    else if (state_q == ST_FETCH)
      op = '{we: 1'b0, idx: ((step_q == 3'd0) ? REG_XFER1 : REG_XFER0), data: 8'h00};
  end

  jts16b_mapper_regacc #(.ADDR_SETUP(ADDR_SETUP)) u_regacc (
    .clk(clk), .rst(rst), .start(start_q), .op(op), .done(acc_done), .rdata(acc_rdata),
    .mcu_addr(mcu_addr), .mcu_dout(mcu_dout), .mcu_wr(mcu_wr), .mcu_acc(mcu_acc),
    .mcu_din(mcu_din)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    poll_d   = poll_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    start_d  = 1'b0;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    dout_d   = dout_q;
    hi_d     = hi_q;
    poll_nxt = poll_q + 8'd1;
    case (state_q)
      ST_IDLE: if (req) begin
        state_d = ST_SETUP;
        we_d    = req_we;
        addr_d  = req_addr;
        din_d   = req_din;
        step_d  = 3'd0;
        poll_d  = 8'd0;
        busy_d  = 1'b1;
        start_d = 1'b1;
      end
      ST_SETUP: if (acc_done) begin
        start_d = 1'b1;
        if (step_q == (we_q ? WR_LAST_STEP : RD_LAST_STEP)) begin
          state_d = ST_POLL;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_POLL: if (acc_done) begin
        poll_d = poll_nxt;
        if (!acc_rdata[STATUS_BUSREQ]) begin
          if (we_q) begin
            state_d = ST_DONE; ack_d = 1'b1; busy_d = 1'b0; err_d = 1'b0;
          end else begin
            state_d = ST_FETCH; step_d = 3'd0; start_d = 1'b1;
          end
        end else if (poll_nxt == POLL_LIM) begin
          // Bus never granted: give up, keep the last read data.
          state_d = ST_DONE; ack_d = 1'b1; busy_d = 1'b0; err_d = 1'b1;
        end else begin
          start_d = 1'b1;
        end
      end
      ST_FETCH: if (acc_done) begin
        if (step_q == 3'd0) begin
          hi_d = acc_rdata; step_d = 3'd1; start_d = 1'b1;
        end else begin
          dout_d  = {hi_q, acc_rdata};
          state_d = ST_DONE; ack_d = 1'b1; busy_d = 1'b0; err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      poll_q  <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 23'd0;
      din_q   <= 16'd0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 16'd0;
      hi_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      poll_q  <= poll_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      hi_q    <= hi_d;
    end
  end

  assign busy     = busy_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign req_dout = dout_q;

endmodule

// File: tb/tb_jts16b_mapper_host.sv
// Randomized bench for jts16b_mapper_host with a behavioural mapper model and
// a reference memory keyed by 68000 word address.
module tb_jts16b_mapper_host;

  localparam int POLL_MAX = 255;

  logic        clk = 1'b0;
  logic        rst, req, req_we;
  logic [22:0] req_addr;
  logic [15:0] req_din, req_dout, mcu_addr;
  logic        busy, ack, err, mcu_wr, mcu_acc;
  logic [7:0]  mcu_dout, mcu_din;

  always #5 clk = ~clk;

  jts16b_mapper_host #(.ADDR_SETUP(3), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .busy(busy), .ack(ack), .err(err), .req_dout(req_dout),
    .mcu_addr(mcu_addr), .mcu_dout(mcu_dout), .mcu_wr(mcu_wr), .mcu_acc(mcu_acc),
    .mcu_din(mcu_din)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- mapper model ----------------
  logic [7:0]  regs [32];
  logic [15:0] mem_map [int];
  logic [15:0] ref_mem [int];
  logic [15:0] rd_word;
  int          polls, pend_n;
  bit          stuck;
  logic [7:0]  noise;
  logic [12:0] wlog [$];
  logic [4:0]  rlog [$];
  logic        acc_prev, wr_prev, cur_wr;
  logic [15:0] addr_prev;
  logic [7:0]  dout_prev;
  logic [4:0]  cur_idx;
  int          stable;

  function automatic logic [15:0] dflt(input int w);
    return 16'(w) ^ 16'(w >> 16) ^ 16'h5A5A;
  endfunction

  always_comb begin
    mcu_din = 8'h00;
    case (mcu_addr)
      16'd0:   mcu_din = rd_word[7:0];
      16'd1:   mcu_din = rd_word[15:8];
      16'd2:   mcu_din = {noise[7], (stuck || polls <= pend_n), noise[5:0]};
      default: mcu_din = 8'h00;
    endcase
  end

  initial begin
    int k;
    acc_prev = 0; wr_prev = 0; cur_wr = 0; addr_prev = 0; dout_prev = 0; cur_idx = 0;
    stable = 0; polls = 0; pend_n = 0; noise = 0; rd_word = 0;
    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && !busy) chk("idle_quiet", {30'd0, mcu_acc, mcu_wr}, 32'd0);
      if (mcu_acc && !acc_prev) begin
        cur_idx = mcu_addr[4:0]; cur_wr = 1'b0;
        if (mcu_addr == 16'd2) polls++;
      end
      if (!mcu_acc && acc_prev && !cur_wr) rlog.push_back(cur_idx);
      if (mcu_wr) begin
        chk("wr_addr_hold", {31'd0, (mcu_addr == addr_prev && stable >= 2)}, 32'd1);
        chk("wr_data_hold", {24'd0, mcu_dout}, {24'd0, dout_prev});
        chk("wr_width", {31'd0, wr_prev}, 32'd0);
        cur_wr = 1'b1;
        wlog.push_back({mcu_addr[4:0], mcu_dout});
        regs[mcu_addr[4:0]] = mcu_dout;
        if (mcu_addr == 16'd5) begin
          if (mcu_dout == 8'h01) begin
            k = int'({regs[7][6:0], regs[8], regs[9]});
            mem_map[k] = {regs[0], regs[1]};
          end else if (mcu_dout == 8'h02) begin
            k = int'({regs[10][6:0], regs[11], regs[12]});
            rd_word = mem_map.exists(k) ? mem_map[k] : dflt(k);
          end
          polls = 0; pend_n = $urandom_range(0, 4); noise = 8'($urandom);
        end
      end
      stable    = (mcu_addr == addr_prev) ? stable + 1 : 0;
      addr_prev = mcu_addr; dout_prev = mcu_dout; acc_prev = mcu_acc; wr_prev = mcu_wr;
    end
  end

  // ---------------- expectations ----------------
  logic [12:0] exp_w [$];
  logic [4:0]  exp_r [$];
  logic [15:0] exp_dout;

  task automatic build_exp(input bit we, input logic [23:0] ba, input logic [15:0] d,
                           input int npoll, input bit fetch);
    exp_w.delete(); exp_r.delete();
    if (we) begin
      exp_w.push_back({5'd0, d[15:8]});
      exp_w.push_back({5'd1, d[7:0]});
      exp_w.push_back({5'd7, 8'((ba >> 17) & 24'h7F)});
      exp_w.push_back({5'd8, 8'((ba >> 9) & 24'hFF)});
      exp_w.push_back({5'd9, 8'((ba >> 1) & 24'hFF)});
      exp_w.push_back({5'd5, 8'h01});
    end else begin
      exp_w.push_back({5'd10, 8'((ba >> 17) & 24'h7F)});
      exp_w.push_back({5'd11, 8'((ba >> 9) & 24'hFF)});
      exp_w.push_back({5'd12, 8'((ba >> 1) & 24'hFF)});
      exp_w.push_back({5'd5, 8'h02});
    end
    repeat (npoll) exp_r.push_back(5'd2);
    if (fetch) begin exp_r.push_back(5'd1); exp_r.push_back(5'd0); end
  endtask

  task automatic cmp_logs(input string tag);
    chk({tag, "_wlen"}, wlog.size(), exp_w.size());
    for (int i = 0; i < wlog.size() && i < exp_w.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), {19'd0, wlog[i]}, {19'd0, exp_w[i]});
    chk({tag, "_rlen"}, rlog.size(), exp_r.size());
    for (int i = 0; i < rlog.size() && i < exp_r.size(); i++)
      chk($sformatf("%s_r%0d", tag, i), {27'd0, rlog[i]}, {27'd0, exp_r[i]});
    wlog.delete(); rlog.delete();
  endtask

  task automatic wait_ack(input string tag, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      if (ack) ok = 1'b1;
    end
    chk({tag, "_ack_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic start_req(input bit we, input logic [23:0] ba, input logic [15:0] d);
    req = 1'b1; req_we = we; req_addr = ba[23:1]; req_din = d;
  endtask

  // Called at a negedge; finishes one negedge after the ack pulse.
  task automatic access(input string tag, input bit we, input logic [23:0] ba,
                        input logic [15:0] d, input bit stk);
    bit ok;
    int key;
    key = int'(ba >> 1);
    stuck = stk;
    start_req(we, ba, d);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_ack(tag, ok);
    if (ok) begin
      if (we && !stk) ref_mem[key] = d;
      if (!we && !stk) exp_dout = ref_mem.exists(key) ? ref_mem[key] : dflt(key);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, stk});
      chk({tag, "_dout"}, {16'd0, req_dout}, {16'd0, exp_dout});
      chk({tag, "_busy_ack"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk({tag, "_ack_pulse"}, {31'd0, ack}, 32'd0);
      build_exp(we, ba, d, stk ? POLL_MAX : pend_n + 1, !we && !stk);
      cmp_logs(tag);
    end
    stuck = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok, seen;
    logic [23:0] ba, pool [8];
    logic [15:0] d;
    bit we;
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_din = '0; stuck = 1'b0;
    exp_dout = 16'h0000;
    mem_map[int'(24'h3FFFFE >> 1)] = 16'h1234;
    ref_mem[int'(24'h3FFFFE >> 1)] = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, ack, err, mcu_wr, mcu_acc}, 32'd0);
    chk("rst_addr", {mcu_addr, 8'd0, mcu_dout}, 32'd0);
    chk("rst_dout", {16'd0, req_dout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access("wr_beef", 1'b1, 24'h0C0000, 16'hBEEF, 1'b0);
    access("rd_1234", 1'b0, 24'h3FFFFE, 16'h0000, 1'b0);
    chk("rd_1234_val", {16'd0, req_dout}, 32'h1234);
    access("rd_stuck", 1'b0, 24'h3FFFFE, 16'h0000, 1'b1);
    chk("rd_stuck_keep", {16'd0, req_dout}, 32'h1234);

    // reset while the reg8 write step is in flight
    start_req(1'b1, 24'h123456, 16'hA5A5);
    @(posedge clk); #1 req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (mcu_acc && mcu_addr == 16'd8) seen = 1'b1;
    end
    chk("rst_mid_reach", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {busy, ack, err, mcu_wr, mcu_acc}, 32'd0);
    chk("rst_mid_addr", {mcu_addr, 8'd0, mcu_dout}, 32'd0);
    chk("rst_mid_dout", {16'd0, req_dout}, 32'd0);
    rst = 1'b0; exp_dout = 16'h0000;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (ack) seen = 1'b1; end
    chk("rst_mid_noack", {31'd0, seen}, 32'd0);
    wlog.delete(); rlog.delete();
    access("post_rst", 1'b1, 24'h123456, 16'hA5A5, 1'b0);

    // back-to-back: write then read of the same word with req held high
    ba = 24'($urandom) & 24'hFFFFFE; d = 16'($urandom);
    start_req(1'b1, ba, d);
    @(posedge clk); #1 req_we = 1'b0;
    wait_ack("b2b_wr", ok);
    if (ok) begin
      chk("b2b_wr_err", {31'd0, err}, 32'd0);
      ref_mem[int'(ba >> 1)] = d;
      @(negedge clk);
      chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
      build_exp(1'b1, ba, d, pend_n + 1, 1'b0);
      cmp_logs("b2b_wr");
      @(negedge clk);
      chk("b2b_accept", {31'd0, busy}, 32'd1);
      req = 1'b0;
      wait_ack("b2b_rd", ok);
      if (ok) begin
        exp_dout = d;
        chk("b2b_rd_err", {31'd0, err}, 32'd0);
        chk("b2b_rd_dout", {16'd0, req_dout}, {16'd0, d});
        @(negedge clk);
        build_exp(1'b0, ba, d, pend_n + 1, 1'b1);
        cmp_logs("b2b_rd");
      end
    end
    req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) pool[i] = 24'($urandom) & 24'hFFFFFE;
    for (int i = 0; i < 16; i++) begin
      we = 1'($urandom);
      ba = pool[$urandom_range(0, 7)];
      d  = 16'($urandom);
      access($sformatf("rnd%0d", i), we, ba, d, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
